opb_msg_reader: RTL and testbench
=================================

// Module: opb_msg_reader
// PURPOSE
//  Frame decoder between a host-link RX byte FIFO and the OPB master side. Pops bytes from the
//  FIFO and assembles fixed 10-byte command frames. Each valid frame issues one OPB write or
//  read strobe with a 32-bit address and data. Flags tail errors and inter-byte timeouts,
//  measured in PULSE_2KHZ ticks.
// PARAMETERS
//  TIMEOUT_TICKS  100    PULSE_2KHZ rising edges allowed between bytes inside a frame
//  HDR_WR         8'h5A  header byte for an OPB write frame
//  HDR_RD         8'h5B  header byte for an OPB read frame
// PORTS
//  OPB_CLK        in   1   single system clock; all logic on its rising edge
//  OPB_RST_N      in   1   asynchronous, active-low reset
//  PULSE_2KHZ     in   1   timebase, synchronous to OPB_CLK; each 0->1 transition is one tick
//  RX_FIFO_RD     out  1   FIFO pop request
//  RX_FIFO_DATA   in   8   FIFO read data, valid on the cycle after RX_FIFO_RD
//  RX_FIFO_EMPTY  in   1   FIFO empty
//  OPB_ADDR       out  32  assembled address
//  OPB_DO         out  32  assembled write data
//  OPB_WE         out  1   1-cycle write strobe
//  OPB_RE         out  1   1-cycle read strobe
//  error_flag     out  1   sticky error indicator
// BEHAVIOUR
//  - Reset values: all outputs 0. FSM goes to IDLE, timeout counter 0, PULSE_2KHZ edge register 0.
//  - Reset may be asserted at any time. A partially received frame is discarded, with no strobe.
//  - Frame layout: HDR, ADDR[31:24..7:0], DATA[31:24..7:0], TAIL (10 bytes, MSB first).
//  - TAIL must equal ~HDR: write tail is 8'hA5, read tail is 8'hA4.
//  - FIFO handshake:
//    - RX_FIFO_RD is a 1-cycle pulse, issued only when RX_FIFO_EMPTY=0 and no pop is outstanding.
//    - The byte is captured from RX_FIFO_DATA on the next cycle.
//    - Sustained rate is 1 byte per 2 clocks. RX_FIFO_RD is never asserted while empty.
//  - States: IDLE -> ADDR(4 bytes) -> DATA(4 bytes) -> TAIL -> IDLE.
//  - IDLE behaviour:
//    - A byte equal to HDR_WR or HDR_RD is latched as the command and clears error_flag.
//    - The FSM then enters ADDR. Any other byte is dropped silently and the FSM stays in IDLE.
//  - ADDR/DATA bytes shift into internal address and data registers, MSB first.
//  - TAIL state:
//    - Tail correct, write command: OPB_ADDR and OPB_DO load, and OPB_WE pulses high for
//      exactly 1 cycle on the cycle after the tail is captured.
//    - Tail correct, read command: OPB_ADDR loads and OPB_RE pulses for 1 cycle.
//      OPB_DO is unchanged, and the read frame's data bytes are ignored.
//    - Tail wrong: no strobe, OPB_ADDR and OPB_DO unchanged, error_flag set to 1.
//    - In all three cases the FSM returns to IDLE.
//  - OPB_ADDR and OPB_DO hold their values until the next valid frame.
//  - OPB_WE and OPB_RE are never high together.
//  - Timeout:
//    - Outside IDLE, the counter increments on each PULSE_2KHZ rising edge and clears on every
//      captured byte.
//    - When the counter reaches TIMEOUT_TICKS: error_flag is set, the frame is discarded and the
//      FSM goes to IDLE.
//    - The counter is held at 0 while in IDLE.
//    - If a byte capture and a tick occur in the same cycle, the byte wins and the counter clears.
//  - error_flag stays high until the next accepted header byte, or reset.
//  - The FIFO (afifo, DSIZE=8, ASIZE=4, both clocks tied to OPB_CLK) is external to this block.
// TESTING
//  1. Write frame: bytes 5A AA BB CC DD 11 22 33 44 A5
//     -> one OPB_WE pulse with OPB_ADDR=AABBCCDD, OPB_DO=11223344; error_flag=0.
//  2. Read frame: bytes 5B 12 34 56 78 AA BB CC DD A4
//     -> one OPB_RE pulse with OPB_ADDR=12345678; OPB_DO stays 11223344; OPB_WE stays 0.
//  3. Tail error: bytes 5B 12 34 56 78 AA BB CC DD A5
//     -> no strobe; error_flag=1; OPB_ADDR unchanged.
//  4. Timeout: bytes 5A AA BB CC DD, then stop
//     -> error_flag cleared at 5A; set again after 100 ticks; no OPB_WE; FSM back in IDLE.
//     A following full valid frame must then decode correctly.
//  5. Garbage and reset:
//     - Bytes 00 FF then a valid write frame -> only that frame strobes.
//     - OPB_RST_N pulsed low mid-frame -> outputs 0, no strobe from the partial frame.
//  6. Back-to-back frames written with no gap while the FIFO fills
//     -> every frame strobes once, in order; RX_FIFO_RD is never asserted while empty.

Source files
------------

// File: rtl/opb_msg_reader.sv
// Host-link frame decoder: pops bytes from an RX FIFO, assembles 10-byte command
// frames and issues a single OPB write or read strobe for each valid frame.
module opb_msg_reader #(
  parameter int          TIMEOUT_TICKS = 100,
  parameter logic [7:0]  HDR_WR        = 8'h5A,
  parameter logic [7:0]  HDR_RD        = 8'h5B
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        PULSE_2KHZ,
  output logic        RX_FIFO_RD,
  input  logic [7:0]  RX_FIFO_DATA,
  input  logic        RX_FIFO_EMPTY,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        OPB_WE,
  output logic        OPB_RE,
  output logic        error_flag
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_TAIL
  } state_t;

  state_t        state_q, state_d;
  logic          rd_q, rd_d;
  logic          cap_q, cap_d;
  logic          pulse_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_cmd_q, wr_cmd_d;
  logic [31:0]   addr_sh_q, addr_sh_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [31:0]   opb_addr_q, opb_addr_d;
  logic [31:0]   opb_do_q, opb_do_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          err_q, err_d;

  logic          tick;
  logic [7:0]    rx_byte;
  logic [7:0]    tail_exp;

  assign tick     = PULSE_2KHZ & ~pulse_q;
  assign rx_byte  = RX_FIFO_DATA;
  assign tail_exp = wr_cmd_q ? ~HDR_WR : ~HDR_RD;

  // One pop in flight at a time: rd_q is the outstanding pop, cap_q marks valid data.
  always_comb begin
    rd_d  = ~RX_FIFO_EMPTY & ~rd_q;
    cap_d = rd_q;
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    wr_cmd_d   = wr_cmd_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    opb_addr_d = opb_addr_q;
    opb_do_d   = opb_do_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = err_q;

    if (state_q == S_IDLE || cap_q) begin
      tmo_d = '0;
    end else if (tick) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cap_q && (rx_byte == HDR_WR || rx_byte == HDR_RD)) begin
          wr_cmd_d = (rx_byte == HDR_WR);
          err_d    = 1'b0;
          cnt_d    = 2'd0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cap_q) begin
          addr_sh_d = {addr_sh_q[23:0], rx_byte};
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cap_q) begin
          data_sh_d = {data_sh_q[23:0], rx_byte};
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (cap_q) begin
          state_d = S_IDLE;
          if (rx_byte == tail_exp) begin
            opb_addr_d = addr_sh_q;
            if (wr_cmd_q) begin
              opb_do_d = data_sh_q;
              we_d     = 1'b1;
            end else begin
              re_d     = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A captured byte in the same cycle as a tick keeps the frame alive.
    if (state_q != S_IDLE && !cap_q && tick && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      cap_q      <= 1'b0;
      pulse_q    <= 1'b0;
      tmo_q      <= '0;
      cnt_q      <= 2'd0;
      wr_cmd_q   <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      opb_addr_q <= '0;
      opb_do_q   <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      cap_q      <= cap_d;
      pulse_q    <= PULSE_2KHZ;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      wr_cmd_q   <= wr_cmd_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      opb_addr_q <= opb_addr_d;
      opb_do_q   <= opb_do_d;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
    end
  end

  assign RX_FIFO_RD = rd_q;
  assign OPB_ADDR   = opb_addr_q;
  assign OPB_DO     = opb_do_q;
  assign OPB_WE     = we_q;
  assign OPB_RE     = re_q;
  assign error_flag = err_q;

endmodule

// File: tb/tb_opb_msg_reader.sv
// Self-checking bench for opb_msg_reader: behavioural FIFO, strobe monitor and a
// frame-level reference model that predicts every OPB strobe and the error flag.
module tb_opb_msg_reader;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST_N = 1'b0;
  logic        PULSE_2KHZ = 1'b0;
  logic        RX_FIFO_RD;
  logic [7:0]  RX_FIFO_DATA;
  logic        RX_FIFO_EMPTY;
  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DO;
  logic        OPB_WE;
  logic        OPB_RE;
  logic        error_flag;

  opb_msg_reader dut (
    .OPB_CLK      (OPB_CLK),
    .OPB_RST_N    (OPB_RST_N),
    .PULSE_2KHZ   (PULSE_2KHZ),
    .RX_FIFO_RD   (RX_FIFO_RD),
    .RX_FIFO_DATA (RX_FIFO_DATA),
    .RX_FIFO_EMPTY(RX_FIFO_EMPTY),
    .OPB_ADDR     (OPB_ADDR),
    .OPB_DO       (OPB_DO),
    .OPB_WE       (OPB_WE),
    .OPB_RE       (OPB_RE),
    .error_flag   (error_flag)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  // FIFO model: bench process writes mem/wr_cnt, FIFO process owns rd_cnt/rx_data.
  logic [7:0] mem [0:255];
  logic [7:0] wr_cnt = 8'd0;
  logic [7:0] rd_cnt = 8'd0;
  logic [7:0] rx_data = 8'd0;
  assign RX_FIFO_EMPTY = (wr_cnt == rd_cnt);
  assign RX_FIFO_DATA  = rx_data;

  always @(posedge OPB_CLK) begin
    if (RX_FIFO_RD && !RX_FIFO_EMPTY) begin
      rx_data <= mem[rd_cnt];
      rd_cnt  <= rd_cnt + 8'd1;
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } ev_t;

  ev_t obs_q[$];
  int  both_cnt = 0;
  int  rd_empty_cnt = 0;

  always @(negedge OPB_CLK) begin
    if (OPB_WE || OPB_RE) obs_q.push_back('{OPB_WE, OPB_ADDR, OPB_DO});
    if (OPB_WE && OPB_RE) both_cnt++;
    if (RX_FIFO_RD && RX_FIFO_EMPTY) rd_empty_cnt++;
  end

  ev_t         exp_q[$];
  int          obs_rd = 0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_do = 32'd0;
  logic        m_err = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          tick_en = 1'b0;
  int          tick_div = 0;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge OPB_CLK);
      #1;
      if (tick_en) begin
        tick_div++;
        if (tick_div >= 15) begin
          tick_div   = 0;
          PULSE_2KHZ = ~PULSE_2KHZ;
        end
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    while (8'(wr_cnt - rd_cnt) >= 8'd16 && waited < 1000) begin
      cyc(1);
      waited++;
    end
    mem[wr_cnt] = b;
    wr_cnt      = wr_cnt + 8'd1;
    cyc(gap);
  endtask

  // Reference model: a frame strobes only when its tail is the complement of its header.
  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] addr,
                            input logic [31:0] dat, input logic [7:0] tail, input int gap);
    push_byte(hdr, gap);
    for (int i = 3; i >= 0; i--) push_byte(addr[i*8 +: 8], gap);
    for (int i = 3; i >= 0; i--) push_byte(dat[i*8 +: 8], gap);
    push_byte(tail, gap);
    m_err = 1'b0;
    if (tail == ~hdr) begin
      m_addr = addr;
      if (hdr == 8'h5A) m_do = dat;
      exp_q.push_back('{hdr == 8'h5A, m_addr, m_do});
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (!RX_FIFO_EMPTY && waited < 2000) begin
      cyc(1);
      waited++;
    end
    if (waited >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: fifo still holds %0d bytes, required 0", 8'(wr_cnt - rd_cnt));
    end
    cyc(8);
  endtask

  task automatic test_reset();
    OPB_RST_N = 1'b0;
    cyc(3);
    n_checks++; if (OPB_ADDR !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", OPB_ADDR); end
    n_checks++; if (OPB_DO !== 32'd0) begin n_fail++; $display("FAIL reset_do: got %h required 0", OPB_DO); end
    n_checks++; if ({OPB_WE, OPB_RE} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b required 00", {OPB_WE, OPB_RE}); end
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", error_flag); end
    n_checks++; if (RX_FIFO_RD !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b required 0", RX_FIFO_RD); end
    OPB_RST_N = 1'b1;
    cyc(2);
    $display("test_reset done");
  endtask

  task automatic test_write();
    ev_t o, e;
    send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5, 2);
    drain();
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL write_count: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL write_event: got we=%0b addr=%h do=%h required we=%0b addr=%h do=%h", o.we, o.addr, o.dat, e.we, e.addr, e.dat); end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    n_checks++; if (OPB_ADDR !== 32'hAABBCCDD) begin n_fail++; $display("FAIL write_addr: got %h required AABBCCDD", OPB_ADDR); end
    n_checks++; if (OPB_DO !== 32'h11223344) begin n_fail++; $display("FAIL write_do: got %h required 11223344", OPB_DO); end
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b required 0", error_flag); end
    $display("test_write done: addr=%h do=%h", OPB_ADDR, OPB_DO);
  endtask

  task automatic test_read();
    ev_t o, e;
    send_frame(8'h5B, 32'h12345678, 32'hAABBCCDD, 8'hA4, 2);
    drain();
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL read_count: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL read_event: got we=%0b addr=%h do=%h required we=%0b addr=%h do=%h", o.we, o.addr, o.dat, e.we, e.addr, e.dat); end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    n_checks++; if (OPB_DO !== 32'h11223344) begin n_fail++; $display("FAIL read_do_kept: got %h required 11223344", OPB_DO); end
    n_checks++; if (OPB_ADDR !== 32'h12345678) begin n_fail++; $display("FAIL read_addr: got %h required 12345678", OPB_ADDR); end
    $display("test_read done: addr=%h", OPB_ADDR);
  endtask

  task automatic test_tail_error();
    send_frame(8'h5B, 32'h12345678, 32'hAABBCCDD, 8'hA5, 2);
    drain();
    n_checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL tail_strobe: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    obs_rd = obs_q.size(); exp_q.delete();
    n_checks++; if (error_flag !== m_err) begin n_fail++; $display("FAIL tail_err: got %b required %b", error_flag, m_err); end
    n_checks++; if (OPB_ADDR !== m_addr) begin n_fail++; $display("FAIL tail_addr: got %h required %h", OPB_ADDR, m_addr); end
    $display("test_tail_error done: err=%b", error_flag);
  endtask

  task automatic test_timeout();
    ev_t o, e;
    push_byte(8'h5A, 2); push_byte(8'hAA, 2); push_byte(8'hBB, 2);
    push_byte(8'hCC, 2); push_byte(8'hDD, 2);
    drain();
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_hdr_clear: got %b required 0", error_flag); end
    for (int i = 0; i < 99; i++) begin
      PULSE_2KHZ = 1'b1; cyc(1); PULSE_2KHZ = 1'b0; cyc(1);
    end
    cyc(2);
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b after 99 ticks required 0", error_flag); end
    PULSE_2KHZ = 1'b1; cyc(1); PULSE_2KHZ = 1'b0; cyc(2);
    n_checks++; if (error_flag !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b after 100 ticks required 1", error_flag); end
    n_checks++; if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL timeout_strobe: got %0d strobes required 0", obs_q.size() - obs_rd); end
    obs_rd = obs_q.size();
    send_frame(8'h5A, 32'h0BADF00D, 32'hCAFEBABE, 8'hA5, 2);
    drain();
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL timeout_recover_count: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL timeout_recover_event: got we=%0b addr=%h do=%h required we=%0b addr=%h do=%h", o.we, o.addr, o.dat, e.we, e.addr, e.dat); end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_recover_err: got %b required 0", error_flag); end
    $display("test_timeout done");
  endtask

  task automatic test_garbage();
    ev_t o, e;
    push_byte(8'h00, 2);
    push_byte(8'hFF, 2);
    send_frame(8'h5A, 32'h01020304, 32'h05060708, 8'hA5, 2);
    drain();
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL garbage_count: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL garbage_event: got we=%0b addr=%h do=%h required we=%0b addr=%h do=%h", o.we, o.addr, o.dat, e.we, e.addr, e.dat); end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    $display("test_garbage done");
  endtask

  task automatic test_reset_midframe();
    push_byte(8'h5A, 2); push_byte(8'h01, 2); push_byte(8'h02, 2);
    push_byte(8'h03, 2); push_byte(8'h04, 2);
    drain();
    #3 OPB_RST_N = 1'b0;
    cyc(2);
    n_checks++; if ({OPB_ADDR, OPB_DO} !== 64'd0) begin n_fail++; $display("FAIL midreset_regs: got addr=%h do=%h required 0", OPB_ADDR, OPB_DO); end
    n_checks++; if ({OPB_WE, OPB_RE, error_flag, RX_FIFO_RD} !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got %b required 0000", {OPB_WE, OPB_RE, error_flag, RX_FIFO_RD}); end
    OPB_RST_N = 1'b1;
    m_addr = 32'd0; m_do = 32'd0; m_err = 1'b0;
    cyc(2);
    push_byte(8'hCC, 2); push_byte(8'hDD, 2); push_byte(8'h11, 2);
    push_byte(8'h22, 2); push_byte(8'hA5, 2);
    drain();
    n_checks++; if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL midreset_strobe: got %0d strobes required 0", obs_q.size() - obs_rd); end
    obs_rd = obs_q.size();
    n_checks++; if (OPB_ADDR !== m_addr) begin n_fail++; $display("FAIL midreset_addr: got %h required %h", OPB_ADDR, m_addr); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    logic [7:0] hdr, tail, junk;
    tick_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h5A || junk == 8'h5B) junk = 8'h00;
        push_byte(junk, 1);
      end
      hdr  = $urandom_range(0, 1) ? 8'h5A : 8'h5B;
      tail = ~hdr;
      if ($urandom_range(0, 3) == 0) tail = tail ^ 8'($urandom_range(1, 255));
      send_frame(hdr, $urandom, $urandom, tail, 1);
    end
    drain();
    tick_en = 1'b0;
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d strobes required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_event: got we=%0b addr=%h do=%h required we=%0b addr=%h do=%h", o.we, o.addr, o.dat, e.we, e.addr, e.dat); end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    n_checks++; if (error_flag !== m_err) begin n_fail++; $display("FAIL b2b_err: got %b required %b", error_flag, m_err); end
    n_checks++; if (rd_empty_cnt != 0) begin n_fail++; $display("FAIL b2b_rd_empty: got %0d pops while empty required 0", rd_empty_cnt); end
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL b2b_we_re: got %0d cycles with both strobes required 0", both_cnt); end
    $display("test_back_to_back done: strobes=%0d", obs_q.size());
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tail_error();
    test_timeout();
    test_garbage();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
